// File: rtl/mux_escrita_reg_fila.sv
// mux_escrita_reg_fila
// Picks the destination register of an instruction (rt, rd, SP or RA) and
// queues it as a pending register-bank write. Pending writes retire in
// order on commit and drive a registered one-cycle write strobe. Every
// pending destination is compared against two source addresses to flag
// read-after-write hazards.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset, empties the queue
//   seletor      : 00 rt, 01 rd, 10 SP_ADDR, 11 RA_ADDR
//   instr_rt     : instruction rt field
//   instr_rd     : instruction rd field
//   issue_valid  : request to enqueue the selected destination
//   issue_ready  : queue can accept (not full)
//   commit       : retire the oldest pending write
//   rs_check     : first source address tested for hazard
//   rt_check     : second source address tested for hazard
//   hazard       : a nonzero check address matches a pending entry
//   wr_addr      : registered register-bank write address (held when idle)
//   wr_en        : registered one-cycle register-bank write strobe
//   count        : number of pending entries
//   full / empty : queue occupancy flags
//   underflow    : sticky, set by a commit while empty

module mux_escrita_reg_fila #(
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 4,
  parameter int SP_ADDR = 29,
  parameter int RA_ADDR = 31
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               seletor,
  input  logic [ADDR_W-1:0]        instr_rt,
  input  logic [ADDR_W-1:0]        instr_rd,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic                     commit,
  input  logic [ADDR_W-1:0]        rs_check,
  input  logic [ADDR_W-1:0]        rt_check,
  output logic                     hazard,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic                     wr_en,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [ADDR_W-1:0] SpAddr = ADDR_W'(SP_ADDR);
  localparam logic [ADDR_W-1:0] RaAddr = ADDR_W'(RA_ADDR);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_en_q, wr_en_d;
  logic              underflow_q, underflow_d;

  logic [ADDR_W-1:0] sel_addr;
  logic              accept;
  logic              push;
  logic              pop;

  // Destination select
  always_comb begin
    sel_addr = instr_rt;
    case (seletor)
      2'b00:   sel_addr = instr_rt;
      2'b01:   sel_addr = instr_rd;
      2'b10:   sel_addr = SpAddr;
      default: sel_addr = RaAddr;
    endcase
  end

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign issue_ready = !full;

  // A write to register 0 is accepted but dropped, since r0 is never written.
  // Commit never bypasses an issue in the same cycle: pop only sees old state.
  assign accept = issue_valid && issue_ready;
  assign push   = accept && (sel_addr != '0);
  assign pop    = commit && !empty;

  // Next-state for pointers, occupancy, write port and the sticky flag.
  // Push and pop never hit the same slot: that would need the queue to be
  // both full (push blocked) and empty (pop blocked).
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    valid_d     = valid_q;
    wr_addr_d   = wr_addr_q;
    wr_en_d     = 1'b0;
    underflow_d = underflow_q;

    if (push) begin
      tail_d          = tail_q + PW'(1);
      valid_d[tail_q] = 1'b1;
    end
    if (pop) begin
      head_d          = head_q + PW'(1);
      valid_d[head_q] = 1'b0;
      wr_addr_d       = mem_q[head_q];
      wr_en_d         = 1'b1;
    end
    if (commit && empty) begin
      underflow_d = 1'b1;
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      wr_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_en_q     <= wr_en_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry storage needs no reset; valid_q decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= sel_addr;
    end
  end

  // Hazard: any live entry matching a nonzero source address
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        if ((rs_check != '0) && (rs_check == mem_q[i])) hazard = 1'b1;
        if ((rt_check != '0) && (rt_check == mem_q[i])) hazard = 1'b1;
      end
    end
  end

  assign count     = count_q;
  assign wr_addr   = wr_addr_q;
  assign wr_en     = wr_en_q;
  assign underflow = underflow_q;

endmodule
